// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared IO bus: one master per four-phase handshake_1/handshake_2 transaction, with a watchdog.
// Latency: a request is granted one cycle after it is seen in IDLE; ownership is released one cycle after handshake_2 falls.
// Backpressure: masters hold req until granted; a non-owner waits in IDLE order, and a silent slave is cut off by the watchdog.
module bus_arbiter #(
    parameter int NOS_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int MASTER_W       = (NOS_MASTERS > 1) ? $clog2(NOS_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NOS_MASTERS-1:0] req,
    input  logic                   bus_handshake_1,
    input  logic                   bus_handshake_2,
    output logic [NOS_MASTERS-1:0] grant,
    output logic                   bus_busy,
    output logic                   timeout_err,
    output logic [MASTER_W-1:0]    err_master
);

    // Watchdog is at least 10 bits wide, wider if the timeout needs it.
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;

    typedef enum logic [2:0] {
        IDLE,
        GRANTED,
        H1_HIGH,
        H2_HIGH,
        RELEASE
    } state_t;

    state_t                state;
    logic [MASTER_W-1:0]   sel;
    logic [MASTER_W-1:0]   last;
    logic [MASTER_W-1:0]   next_sel;
    logic                  found;
    logic [WD_W-1:0]       watchdog;
    logic [WD_W-1:0]       wd_inc;
    logic                  wd_expire;
    logic [NOS_MASTERS-1:0] next_grant;

    // Round-robin search: first requester after the previous owner, wrapping to 0.
    always_comb begin
        found    = 1'b0;
        next_sel = '0;
        for (int i = 1; i <= NOS_MASTERS; i++) begin
            if (!found && req[MASTER_W'((int'(last) + i) % NOS_MASTERS)]) begin
                found    = 1'b1;
                next_sel = MASTER_W'((int'(last) + i) % NOS_MASTERS);
            end
        end
    end

    // One-hot grant for the chosen master and the watchdog's next value.
    always_comb begin
        next_grant = {{(NOS_MASTERS-1){1'b0}}, 1'b1} << next_sel;
        wd_inc     = watchdog + 1'b1;
        wd_expire  = (wd_inc == WD_W'(TIMEOUT_CYCLES));
    end

    // Arbitration FSM; every output is a register so grant never glitches on req.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            bus_busy    <= 1'b0;
            timeout_err <= 1'b0;
            err_master  <= '0;
            sel         <= '0;
            last        <= MASTER_W'(NOS_MASTERS - 1);
            watchdog    <= '0;
        end else begin
            timeout_err <= 1'b0;
            if (state == IDLE) begin
                watchdog <= '0;
                if (found) begin
                    sel      <= next_sel;
                    grant    <= next_grant;
                    bus_busy <= 1'b1;
                    state    <= GRANTED;
                end
            end else begin
                watchdog <= wd_inc;
                if (wd_expire) begin
                    // Timeout wins over any handshake edge seen this cycle.
                    grant       <= '0;
                    bus_busy    <= 1'b0;
                    timeout_err <= 1'b1;
                    err_master  <= sel;
                    last        <= sel;
                    state       <= IDLE;
                end else begin
                    case (state)
                        GRANTED: begin
                            if (bus_handshake_1) begin
                                state <= H1_HIGH;
                            end else if (!req[sel]) begin
                                grant    <= '0;
                                bus_busy <= 1'b0;
                                last     <= sel;
                                state    <= IDLE;
                            end
                        end
                        H1_HIGH: begin
                            if (bus_handshake_2) state <= H2_HIGH;
                        end
                        H2_HIGH: begin
                            if (!bus_handshake_1) state <= RELEASE;
                        end
                        RELEASE: begin
                            if (!bus_handshake_2) begin
                                grant    <= '0;
                                bus_busy <= 1'b0;
                                last     <= sel;
                                state    <= IDLE;
                            end
                        end
                        default: begin
                            grant    <= '0;
                            bus_busy <= 1'b0;
                            state    <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: four masters, short watchdog, directed scenarios then random traffic.
// A transaction-level model predicts grant/busy/timeout/err_master every cycle.
// Handshake and request stimulus reacts to the DUT grant only to stay protocol-plausible.
module tb_bus_arbiter;
    localparam int N  = 4;
    localparam int T  = 15;
    localparam int MW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic          h1, h2;
    logic [N-1:0]  grant;
    logic          busy, tmo;
    logic [MW-1:0] errm;

    int n_checks = 0;
    int n_pass   = 0;

    bus_arbiter #(.NOS_MASTERS(N), .TIMEOUT_CYCLES(T), .MASTER_W(MW)) dut (
        .clk(clk), .reset(reset), .req(req),
        .bus_handshake_1(h1), .bus_handshake_2(h2),
        .grant(grant), .bus_busy(busy), .timeout_err(tmo), .err_master(errm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- transaction-level reference model ----------------
    // owner: -1 when bus is free. phase counts handshake events seen:
    // 0 wait H1 rise, 1 wait H2 rise, 2 wait H1 fall, 3 wait H2 fall.
    int m_owner, m_last, m_age, m_phase, m_errm;
    bit m_tmo;

    function automatic bit event_seen(input int ph, input logic a, input logic b);
        case (ph)
            0: return a;
            1: return b;
            2: return !a;
            default: return !b;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = -1; m_last = N - 1; m_age = 0; m_phase = 0; m_tmo = 0; m_errm = 0;
        end else begin
            m_tmo = 0;
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_last + k) % N;
                    if (m_owner < 0 && ((req >> idx) & 1) != 0) m_owner = idx;
                end
                m_age = 0; m_phase = 0;
            end else begin
                m_age++;
                if (m_age == T) begin
                    m_tmo = 1; m_errm = m_owner; m_last = m_owner; m_owner = -1;
                end else if (m_phase == 0 && !h1 && ((req >> m_owner) & 1) == 0) begin
                    m_last = m_owner; m_owner = -1;
                end else if (event_seen(m_phase, h1, h2)) begin
                    m_phase++;
                    if (m_phase == 4) begin m_last = m_owner; m_owner = -1; end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [N-1:0] eg;
        eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        check("model_grant", grant, eg);
        check("model_busy", busy, m_owner >= 0);
        check("model_timeout_err", tmo, m_tmo);
        check("model_err_master", errm, m_errm);
    end

    // ---------------- directed helpers ----------------
    task automatic do_reset();
        reset = 1'b1; req = '0; h1 = 0; h2 = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic do_txn(output logic [N-1:0] g);
        int w;
        w = 0;
        tick();
        while (grant == '0 && w < 20) begin tick(); w++; end
        if (grant == '0) begin
            n_checks++;
            $display("FAIL txn_wait: got grant %0h expected a grant within 20 cycles", grant);
        end
        g = grant;
        h1 = 1; tick(); h2 = 1; tick(); h1 = 0; tick(); h2 = 0; tick();
        check("txn_gap_grant", grant, 0);
    endtask

    logic [N-1:0] g;

    initial begin
        reset = 1'b1; req = '0; h1 = 0; h2 = 0;
        tick(); tick();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_tmo", tmo, 0);
        check("rst_errm", errm, 0);
        reset = 1'b0;
        tick();

        // Single full transaction by master 0.
        req = 4'b0001;
        tick();
        check("s1_grant", grant, 4'b0001);
        check("s1_busy", busy, 1);
        tick(); h1 = 1; tick(); tick(); h2 = 1; tick(); tick(); h1 = 0; tick(); tick();
        check("s1_hold", grant, 4'b0001);
        h2 = 0; req = '0;
        tick();
        check("s1_release", grant, 0);
        check("s1_busy_off", busy, 0);
        check("s1_no_tmo", tmo, 0);
        tick();
        check("s1_idle", grant, 0);

        // Continuous requests from masters 0 and 1 alternate ownership.
        do_reset();
        req = 4'b0011;
        do_txn(g); check("s2_g0", g, 4'b0001);
        do_txn(g); check("s2_g1", g, 4'b0010);
        do_txn(g); check("s2_g2", g, 4'b0001);
        do_txn(g); check("s2_g3", g, 4'b0010);

        // Master 1 withdraws before handshake_1.
        do_reset();
        req = 4'b0010;
        tick();
        check("s3_grant1", grant, 4'b0010);
        req = 4'b0000;
        tick();
        check("s3_dropped", grant, 0);
        check("s3_idle", busy, 0);
        req = 4'b0011;
        tick();
        check("s3_next_m0", grant, 4'b0001);

        // Watchdog: slave never answers.
        do_reset();
        req = 4'b0011;
        tick();
        check("s4_grant0", grant, 4'b0001);
        h1 = 1;
        repeat (14) tick();
        check("s4_before_to", grant, 4'b0001);
        check("s4_before_tmo", tmo, 0);
        tick();
        check("s4_to_grant", grant, 0);
        check("s4_to_pulse", tmo, 1);
        check("s4_errm", errm, 0);
        h1 = 0;
        tick();
        check("s4_next_m1", grant, 4'b0010);
        check("s4_pulse_end", tmo, 0);

        // Async reset while in H2_HIGH with master 1 owning the bus.
        h1 = 1; tick(); h2 = 1; tick();
        #1 reset = 1'b1;
        #1;
        check("s5_async_grant", grant, 0);
        check("s5_async_tmo", tmo, 0);
        h1 = 0; h2 = 0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("s5_restart_m0", grant, 4'b0001);

        // Pointer wrap after master 3 owned the bus.
        do_reset();
        req = 4'b1000;
        tick();
        check("s6_grant3", grant, 4'b1000);
        req = 4'b0000;
        tick();
        req = 4'b1001;
        tick();
        check("s6_wrap_m0", grant, 4'b0001);
        req = 4'b1000;
        tick(); tick();
        check("s6_then_m3", grant, 4'b1000);

        // Random traffic.
        do_reset();
        begin
            int ph;
            bit stall;
            logic [N-1:0] prev;
            int own;
            ph = 0; stall = 0; prev = '0;
            for (int c = 0; c < 3000; c++) begin
                tick();
                if ($urandom_range(0, 599) == 0) begin
                    #1 reset = 1'b1;
                    #2 reset = 1'b0;
                    h1 = 0; h2 = 0; ph = 0;
                end
                if (grant == '0) begin
                    h1 = 0; h2 = 0; ph = 0;
                    for (int k = 0; k < N; k++)
                        if ($urandom_range(0, 3) == 0) req[k] = 1'b1;
                end else begin
                    own = 0;
                    for (int k = 0; k < N; k++) if (grant[k]) own = k;
                    if (prev == '0) stall = ($urandom_range(0, 7) == 0);
                    if ($urandom_range(0, 9) == 0) begin
                        int o;
                        o = $urandom_range(0, N - 1);
                        if (o != own) req[o] = ~req[o];
                    end
                    if (!stall && $urandom_range(0, 1) == 0) begin
                        case (ph)
                            0: if ($urandom_range(0, 9) == 0) req[own] = 1'b0;
                               else begin h1 = 1; ph = 1; end
                            1: begin h2 = 1; ph = 2; end
                            2: begin h1 = 0; ph = 3; end
                            default: begin
                                h2 = 0; ph = 4;
                                if ($urandom_range(0, 1) == 0) req[own] = 1'b0;
                            end
                        endcase
                    end
                end
                prev = grant;
            end
        end
        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
